// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and bus-width defaults for the cache-to-memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int CacheMemAddrBus = 32;
    localparam int CacheMemDataBus = 128;
    localparam int CacheMemByteBus = CacheMemDataBus / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RDWAIT = 2'd2
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner select: round-robin from ptr, or fixed lowest-index priority.
module arb_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    int start;
    assign start = mode ? int'(ptr) : 0;

    function automatic int wrap(input int v);
        return v % N;
    endfunction

    // Scan from the far end so the requester closest to start is written last.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int off = N - 1; off >= 0; off--) begin
            if ((req & (N'(1) << wrap(start + off))) != '0) begin
                grant = N'(1) << wrap(start + off);
                idx   = IDX_W'(wrap(start + off));
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master to 1-slave memory bus arbiter, one transaction in flight, with a
// read-response watchdog.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = CacheMemAddrBus,
    parameter int DATA_W      = CacheMemDataBus,
    parameter int BE_W        = DATA_W / 8,
    parameter int RR_MODE     = 1,
    parameter int TIMEOUT     = 1023
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*BE_W-1:0]   m_byte_en,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    output logic [DATA_W-1:0]             m_readdata,
    output logic [NUM_MASTERS-1:0]        m_readdata_valid,
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [BE_W-1:0]               s_byte_en,
    output logic [DATA_W-1:0]             s_writedata,
    output logic                          s_read,
    output logic                          s_write,
    input  logic [DATA_W-1:0]             s_readdata,
    input  logic                          s_readdata_valid,
    input  logic                          s_waitrequest,
    output logic [NUM_MASTERS-1:0]        grant_o,
    output logic                          err_o
);

    localparam int IDX_W = idx_width(NUM_MASTERS);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e             state;
    logic [IDX_W-1:0]       gidx, rr_ptr, pick_idx, next_ptr;
    logic [NUM_MASTERS-1:0] req, pick_grant;
    logic [CNT_W-1:0]       cnt;
    logic g_read, g_write, in_cmd, accept, rd_accept, wr_accept;
    logic rd_done_now, rd_done, timeout_hit, spurious, conflict;

    assign req = m_read | m_write;

    arb_rr_pick #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .mode  (RR_MODE != 0),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign g_read  = m_read[gidx];
    assign g_write = m_write[gidx];
    assign in_cmd  = (state == CMD);

    // A master raising both strobes gets its write forwarded; the read is dropped.
    assign s_write     = in_cmd & g_write;
    assign s_read      = in_cmd & g_read & ~g_write;
    assign s_addr      = in_cmd ? m_addr[gidx*ADDR_W +: ADDR_W] : '0;
    assign s_byte_en   = in_cmd ? m_byte_en[gidx*BE_W +: BE_W] : '0;
    assign s_writedata = in_cmd ? m_writedata[gidx*DATA_W +: DATA_W] : '0;

    assign accept      = in_cmd & ~s_waitrequest & (g_read | g_write);
    assign rd_accept   = accept & s_read;
    assign wr_accept   = accept & s_write;
    assign rd_done_now = rd_accept & s_readdata_valid;
    assign rd_done     = ((state == RDWAIT) & s_readdata_valid) | rd_done_now;
    assign timeout_hit = (TIMEOUT != 0) && (state == RDWAIT) && !s_readdata_valid &&
                         (cnt == CNT_W'(TIMEOUT - 1));
    assign spurious    = s_readdata_valid & ((state == IDLE) | (in_cmd & ~rd_accept));
    assign conflict    = wr_accept & g_read;

    assign err_o            = spurious | timeout_hit | conflict;
    assign m_readdata       = timeout_hit ? '0 : s_readdata;
    assign m_readdata_valid = grant_o & {NUM_MASTERS{rd_done | timeout_hit}};
    assign m_waitrequest    = in_cmd ? ~(grant_o & {NUM_MASTERS{~s_waitrequest}}) : '1;

    assign next_ptr = (gidx == IDX_W'(NUM_MASTERS - 1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gidx    <= '0;
            grant_o <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_o <= pick_grant;
                        gidx    <= pick_idx;
                        state   <= CMD;
                    end
                end
                CMD: begin
                    if (!(g_read | g_write)) begin
                        grant_o <= '0;
                        state   <= IDLE;
                    end else if (wr_accept || rd_done_now) begin
                        grant_o <= '0;
                        rr_ptr  <= next_ptr;
                        state   <= IDLE;
                    end else if (rd_accept) begin
                        cnt   <= '0;
                        state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    if (cnt != CNT_W'(TIMEOUT)) cnt <= cnt + 1'b1;
                    if (rd_done || timeout_hit) begin
                        grant_o <= '0;
                        rr_ptr  <= next_ptr;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- N-master to 1-slave arbiter for the cache-to-memory bus (addr / byte_en / writedata / read / write / readdata / readdata_valid / waitrequest).
- Sits between the core's icache and dcache memory ports, plus optional DMA/debug masters, and the single external memory port.
- Keeps one transaction outstanding at a time.
- Selectable round-robin or fixed priority, with a response-timeout watchdog.

Parameters:
- NUM_MASTERS, 2, number of master ports (index 0 = icache, 1 = dcache).
- ADDR_W, 32, address width.
- DATA_W, 128, data width (one cache line per beat).
- BE_W, DATA_W/8, byte-enable width.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
- TIMEOUT, 1023, maximum cycles from read accept to readdata_valid; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- m_addr  in  NUM_MASTERS*ADDR_W  packed master addresses (master i at slice i).
- m_byte_en  in  NUM_MASTERS*BE_W  packed byte enables.
- m_writedata  in  NUM_MASTERS*DATA_W  packed write data.
- m_read  in  NUM_MASTERS  read request per master.
- m_write  in  NUM_MASTERS  write request per master.
- m_readdata  out  DATA_W  read data, broadcast to all masters.
- m_readdata_valid  out  NUM_MASTERS  per-master read-data-valid strobe.
- m_waitrequest  out  NUM_MASTERS  per-master stall.
- s_addr  out  ADDR_W  slave address.
- s_byte_en  out  BE_W  slave byte enable.
- s_writedata  out  DATA_W  slave write data.
- s_read  out  1  slave read strobe.
- s_write  out  1  slave write strobe.
- s_readdata  in  DATA_W  slave read data.
- s_readdata_valid  in  1  slave read-data-valid.
- s_waitrequest  in  1  slave stall.
- grant_o  out  NUM_MASTERS  one-hot current owner (debug).
- err_o  out  1  one-cycle error pulse.

Behaviour:
- Reset values:
  - state = IDLE, rr_ptr = 0, grant_o = 0.
  - s_read = s_write = 0; s_addr, s_byte_en, s_writedata = 0.
  - m_waitrequest = all 1s; m_readdata_valid = 0; err_o = 0; timeout counter = 0.
- Reset mid-transaction: abandons the transaction with no response to the master. A late s_readdata_valid arriving after reset is treated as spurious (see err_o rules).
- Request vector: req[i] = m_read[i] | m_write[i].
- IDLE:
  - All m_waitrequest = 1; no slave strobes.
  - If req != 0, the arbiter picks a winner and registers grant_o. Next state = CMD.
  - RR_MODE = 1: winner is the first requester at or after rr_ptr, searching upward modulo NUM_MASTERS.
  - RR_MODE = 0: winner is the lowest index with req set.
- CMD:
  - s_* are driven combinationally from the granted master's slices.
  - m_waitrequest[g] = s_waitrequest; all other masters see 1.
  - A command is accepted when s_waitrequest = 0 and s_read | s_write = 1.
  - Write accepted: next state = IDLE, rr_ptr = g+1 (wraps to 0 at NUM_MASTERS).
  - Read accepted: next state = RDWAIT, timeout counter cleared.
  - If s_readdata_valid = 1 in the accept cycle, the read completes at once: route the data, next state = IDLE.
  - If the granted master drops read and write before acceptance: next state = IDLE, rr_ptr unchanged.
- Read and write asserted together by one master: the write is forwarded, s_read is forced to 0, and err_o pulses.
- RDWAIT:
  - m_waitrequest = all 1s.
  - On s_readdata_valid = 1: m_readdata_valid[g] = 1 for exactly that cycle; next state = IDLE; rr_ptr = g+1.
  - Otherwise the counter increments. When the counter reaches TIMEOUT (if TIMEOUT != 0): err_o pulses, m_readdata_valid[g] = 1 with m_readdata = 0, next state = IDLE.
- m_readdata is driven combinationally from s_readdata; only m_readdata_valid is demultiplexed.
- Throughput: minimum of 2 cycles per write (IDLE → CMD). The winner is never pre-empted while in CMD or RDWAIT.
- Spurious s_readdata_valid in IDLE or CMD without a read in flight: dropped, err_o pulses.
- Counter width: clog2(TIMEOUT+1); it does not wrap past TIMEOUT.

Decomposition:
- Shared defines header:
  - State encoding: IDLE = 2'd0, CMD = 2'd1, RDWAIT = 2'd2.
  - Bus-width macros (CacheMemAddrBus / CacheMemDataBus / CacheMemByteBus) as ADDR_W / DATA_W / BE_W defaults.
- Sub-module arb_rr_pick: combinational. Inputs req[N], ptr, mode. Outputs one-hot grant and encoded index.
- Top-level holds the FSM, rr_ptr, the timeout counter and the muxes.

Test Plan:
- Single master: m1 read addr 0x100, s_waitrequest high for 2 cycles, s_readdata_valid 3 cycles after accept with data 0xA5..A5 → m_readdata_valid[1] pulses once with that data; m_waitrequest[0] stays 1 throughout.
- Contention, RR_MODE = 1: m0 and m1 both issue back-to-back writes → grants alternate 0,1,0,1; each write completes in 2 cycles with a zero-wait slave.
- Contention, RR_MODE = 0: m0 and m1 both request continuously → m0 wins every arbitration; m1 is granted only when m0 is idle.
- Zero-latency read: s_waitrequest = 0 and s_readdata_valid = 1 in the CMD cycle → valid routed to master g the same cycle; state returns to IDLE; no RDWAIT cycle.
- Timeout with TIMEOUT = 8: read accepted, no s_readdata_valid → at the 8th RDWAIT cycle err_o = 1, m_readdata_valid[g] = 1, m_readdata = 0; the next request is arbitrated normally.
- Reset mid-RDWAIT, then s_readdata_valid arrives → all outputs at reset values; the late valid raises err_o and is not routed to any master.
